// File: rtl/window_variance_calc.sv
// Window variance unit: reads the four integral and squared-integral corners of one
// detection window, forms sum/sqsum by inclusion-exclusion and WIN*WIN*sqsum - sum*sum.
module window_variance_calc #(
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int INT_DATA_W = 27,
    parameter int SQ_DATA_W  = 35,
    parameter int WIN        = 20,
    parameter int VAR_W      = 48
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [X_W-1:0]        winX,
    input  logic [Y_W-1:0]        winY,
    input  logic [X_W-1:0]        imgW,
    input  logic [Y_W-1:0]        imgH,
    output logic                  ready,
    output logic                  rd_en,
    output logic [X_W-1:0]        raddrX,
    output logic [Y_W-1:0]        raddrY,
    input  logic [INT_DATA_W-1:0] int_q,
    input  logic [SQ_DATA_W-1:0]  sq_q,
    output logic                  done,
    input  logic                  taken,
    output logic                  err,
    output logic [INT_DATA_W-1:0] sum,
    output logic [SQ_DATA_W-1:0]  sqsum,
    output logic [VAR_W-1:0]      variance
);

    // state | meaning
    // IDLE  | ready, waiting for start; bounds check on request
    // ISSUE | four corner reads A, B, C, D (idx 0..3)
    // DRAIN | last read word (D) returns
    // MULT  | register WIN*WIN*sqsum and sum*sum
    // SUB   | saturating subtract into variance
    // DONE  | result held until taken
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_MULT,
        S_SUB,
        S_DONE
    } state_t;

    localparam logic [VAR_W-1:0] WIN_SQ = VAR_W'(WIN * WIN);

    state_t                  r_state;
    state_t                  w_next;
    logic [1:0]              r_idx;
    logic [X_W-1:0]          r_x;
    logic [Y_W-1:0]          r_y;
    logic                    r_vld;
    logic                    r_neg;
    logic                    r_err;
    logic [INT_DATA_W-1:0]   r_sum;
    logic [SQ_DATA_W-1:0]    r_sqsum;
    logic [VAR_W-1:0]        r_p1;
    logic [VAR_W-1:0]        r_p2;
    logic [VAR_W-1:0]        r_var;
    logic                    w_oob;

    // Widened by one bit so a window near the top of the coordinate range cannot wrap.
    assign w_oob = (({1'b0, winX} + (X_W+1)'(WIN)) > {1'b0, imgW}) ||
                   (({1'b0, winY} + (Y_W+1)'(WIN)) > {1'b0, imgH});

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = w_oob ? S_DONE : S_ISSUE;
            S_ISSUE: if (r_idx == 2'd3) w_next = S_DRAIN;
            S_DRAIN: w_next = S_MULT;
            S_MULT:  w_next = S_SUB;
            S_SUB:   w_next = S_DONE;
            S_DONE:  if (taken) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready  = (r_state == S_IDLE);
        done   = (r_state == S_DONE);
        rd_en  = (r_state == S_ISSUE);
        raddrX = '0;
        raddrY = '0;
        if (rd_en) begin
            raddrX = r_idx[0] ? (r_x + X_W'(WIN)) : r_x;
            raddrY = r_idx[1] ? (r_y + Y_W'(WIN)) : r_y;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_idx   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_vld   <= 1'b0;
            r_neg   <= 1'b0;
            r_err   <= 1'b0;
            r_sum   <= '0;
            r_sqsum <= '0;
            r_p1    <= '0;
            r_p2    <= '0;
            r_var   <= '0;
        end else begin
            // Read data lags the address by one cycle; B and C carry a negative sign.
            r_vld <= rd_en;
            r_neg <= r_idx[0] ^ r_idx[1];
            if (r_vld) begin
                if (r_neg) begin
                    r_sum   <= r_sum - int_q;
                    r_sqsum <= r_sqsum - sq_q;
                end else begin
                    r_sum   <= r_sum + int_q;
                    r_sqsum <= r_sqsum + sq_q;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x     <= winX;
                        r_y     <= winY;
                        r_err   <= w_oob;
                        r_sum   <= '0;
                        r_sqsum <= '0;
                        r_var   <= '0;
                        r_idx   <= '0;
                    end
                end
                S_ISSUE: r_idx <= r_idx + 2'd1;
                S_MULT: begin
                    r_p1 <= WIN_SQ * VAR_W'(r_sqsum);
                    r_p2 <= VAR_W'(r_sum) * VAR_W'(r_sum);
                end
                S_SUB:   r_var <= (r_p2 > r_p1) ? '0 : (r_p1 - r_p2);
                default: ;
            endcase
        end
    end

    assign err      = r_err;
    assign sum      = r_sum;
    assign sqsum    = r_sqsum;
    assign variance = r_var;

endmodule

// File: tb/tb_window_variance_calc.sv
// Bench for window_variance_calc: pixel images behind modelled integral caches,
// results compared against direct pixel summation of each window.
module tb_window_variance_calc;

    localparam int X_W = 10, Y_W = 9, INT_DATA_W = 27, SQ_DATA_W = 35, WIN = 20, VAR_W = 48;
    localparam int N = 64;

    logic                  clk = 1'b0;
    logic                  resetn = 1'b0;
    logic                  start = 1'b0;
    logic [X_W-1:0]        winX = '0;
    logic [Y_W-1:0]        winY = '0;
    logic [X_W-1:0]        imgW = '0;
    logic [Y_W-1:0]        imgH = '0;
    logic                  ready, rd_en, done, err;
    logic [X_W-1:0]        raddrX;
    logic [Y_W-1:0]        raddrY;
    logic [INT_DATA_W-1:0] int_q = '0;
    logic [SQ_DATA_W-1:0]  sq_q = '0;
    logic                  taken = 1'b0;
    logic [INT_DATA_W-1:0] sum;
    logic [SQ_DATA_W-1:0]  sqsum;
    logic [VAR_W-1:0]      variance;

    window_variance_calc #(
        .X_W(X_W), .Y_W(Y_W), .INT_DATA_W(INT_DATA_W), .SQ_DATA_W(SQ_DATA_W),
        .WIN(WIN), .VAR_W(VAR_W)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .winX(winX), .winY(winY),
        .imgW(imgW), .imgH(imgH), .ready(ready), .rd_en(rd_en), .raddrX(raddrX),
        .raddrY(raddrY), .int_q(int_q), .sq_q(sq_q), .done(done), .taken(taken),
        .err(err), .sum(sum), .sqsum(sqsum), .variance(variance)
    );

    always #5 clk = ~clk;

    int     pix [0:N-1][0:N-1];
    longint ii  [0:N][0:N];
    longint sqi [0:N][0:N];
    bit     ovr_mode = 1'b0;
    longint ovr_i [0:3];
    longint ovr_s [0:3];
    int     cur_x = 0, cur_y = 0;
    int     n_err = 0, n_checks = 0;
    int     rd_cnt = 0;
    bit     both_seen = 1'b0;
    int     obs_maxx = 0;
    longint exp_s, exp_sq, exp_v;
    bit     exp_e;
    int     corner;

    // Cache model: one-cycle read latency, or forced corner words in override mode.
    always @(posedge clk) begin
        if (rd_en) begin
            if (ovr_mode) begin
                corner = ((int'(raddrX) == cur_x) ? 0 : 1) + ((int'(raddrY) == cur_y) ? 0 : 2);
                int_q <= INT_DATA_W'(ovr_i[corner]);
                sq_q  <= SQ_DATA_W'(ovr_s[corner]);
            end else if (int'(raddrX) <= N && int'(raddrY) <= N) begin
                int_q <= INT_DATA_W'(ii[int'(raddrY)][int'(raddrX)]);
                sq_q  <= SQ_DATA_W'(sqi[int'(raddrY)][int'(raddrX)]);
            end
        end
    end

    always @(negedge clk) begin
        if (rd_en) rd_cnt <= rd_cnt + 1;
        if (ready && done) both_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic build_ii();
        for (int y = 0; y <= N; y++)
            for (int x = 0; x <= N; x++) begin
                ii[y][x]  = 0;
                sqi[y][x] = 0;
                if (x > 0 && y > 0) begin
                    ii[y][x]  = longint'(pix[y-1][x-1]) + ii[y-1][x] + ii[y][x-1] - ii[y-1][x-1];
                    sqi[y][x] = longint'(pix[y-1][x-1]) * pix[y-1][x-1] + sqi[y-1][x]
                                + sqi[y][x-1] - sqi[y-1][x-1];
                end
            end
    endtask

    // Reference: plain summation over the window's pixels.
    task automatic ref_win(input int x, input int y, input int w, input int h);
        exp_e  = (x + WIN > w) || (y + WIN > h);
        exp_s  = 0;
        exp_sq = 0;
        exp_v  = 0;
        if (!exp_e) begin
            for (int j = y; j < y + WIN; j++)
                for (int i = x; i < x + WIN; i++) begin
                    exp_s  += pix[j][i];
                    exp_sq += longint'(pix[j][i]) * pix[j][i];
                end
            exp_v = longint'(WIN * WIN) * exp_sq - exp_s * exp_s;
            if (exp_v < 0) exp_v = 0;
        end
    endtask

    // Starts in the cycle where start is driven (T); returns in cycle T+1 (error) or T+8.
    task automatic do_window(input int x, input int y, input int w, input int h, input bit noise);
        cur_x = x; cur_y = y;
        winX = X_W'(x); winY = Y_W'(y); imgW = X_W'(w); imgH = Y_W'(h);
        start = 1'b1;
        check("ready_at_start", ready, 1);
        @(posedge clk); #1;
        start = 1'b0;
        obs_maxx = 0;
        if (exp_e) begin
            check("err_done_t1", done, 1);
        end else begin
            for (int c = 0; c < 4; c++) begin
                check("issue_rd_en", rd_en, 1);
                check("issue_addr_x", raddrX, (c % 2 == 1) ? x + WIN : x);
                check("issue_addr_y", raddrY, (c >= 2) ? y + WIN : y);
                if (int'(raddrX) > obs_maxx) obs_maxx = int'(raddrX);
                if (noise && c == 1) begin start = 1'b1; winX = '0; end
                @(posedge clk); #1;
                start = 1'b0; winX = X_W'(x);
            end
            for (int c = 0; c < 3; c++) begin
                check("pipe_not_done", done, 0);
                check("pipe_rd_en_low", rd_en, 0);
                @(posedge clk); #1;
            end
            check("done_t8", done, 1);
        end
        check("res_err", err, exp_e);
        check("res_sum", sum, exp_s);
        check("res_sqsum", sqsum, exp_sq);
        check("res_variance", variance, exp_v);
        check("done_not_ready", ready, 0);
    endtask

    task automatic take(input int dly, input bit noise);
        for (int i = 0; i < dly; i++) begin
            if (noise && i == 1) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check("hold_done", done, 1);
            check("hold_sum", sum, exp_s);
            check("hold_variance", variance, exp_v);
        end
        taken = 1'b1;
        @(posedge clk); #1;
        taken = 1'b0;
        check("taken_ready", ready, 1);
        check("taken_done_low", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        #12;
        check("rst_ready", ready, 1);
        check("rst_rd_en", rd_en, 0);
        check("rst_raddrX", raddrX, 0);
        check("rst_raddrY", raddrY, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_sum", sum, 0);
        check("rst_sqsum", sqsum, 0);
        check("rst_variance", variance, 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // constant image
        for (int y = 0; y < N; y++) for (int x = 0; x < N; x++) pix[y][x] = 10;
        build_ii();
        exp_e = 0; exp_s = 4000; exp_sq = 40000; exp_v = 0;
        do_window(7, 3, 64, 64, 0);
        take(0, 0);

        // checkerboard, with a slow consumer and start noise in DONE
        for (int y = 0; y < N; y++) for (int x = 0; x < N; x++) pix[y][x] = ((x + y) % 2 == 1) ? 2 : 0;
        build_ii();
        exp_e = 0; exp_s = 400; exp_sq = 800; exp_v = 160000;
        do_window(0, 0, 64, 64, 0);
        take(5, 1);

        // bounds
        snap = rd_cnt;
        ref_win(5, 0, 24, 64);
        do_window(5, 0, 24, 64, 0);
        take(0, 0);
        check("oob_no_reads", rd_cnt, snap);
        ref_win(4, 0, 24, 64);
        do_window(4, 0, 24, 64, 0);
        check("max_rd_x", obs_maxx, 24);
        take(0, 0);

        // forced corner words: modular wrap and saturating subtract
        ovr_mode = 1'b1;
        ovr_i[0] = 134217700; ovr_i[1] = 50; ovr_i[2] = 60; ovr_i[3] = 4100;
        ovr_s[0] = 100; ovr_s[1] = 10; ovr_s[2] = 20; ovr_s[3] = 30;
        exp_e = 0; exp_s = 3962; exp_sq = 100; exp_v = 0;
        do_window(10, 10, 64, 64, 0);
        take(0, 0);
        ovr_mode = 1'b0;

        // taken in IDLE is ignored
        taken = 1'b1;
        @(posedge clk); #1;
        taken = 1'b0;
        check("idle_taken_ready", ready, 1);
        check("idle_taken_done", done, 0);

        // random image, random windows back to back, start noise in ISSUE
        for (int y = 0; y < N; y++) for (int x = 0; x < N; x++) pix[y][x] = int'($urandom_range(0, 255));
        build_ii();
        for (int k = 0; k < 8; k++) begin
            int x, y, w, h;
            x = int'($urandom_range(0, 44));
            y = int'($urandom_range(0, 44));
            w = (k % 3 == 2) ? int'($urandom_range(20, 64)) : 64;
            h = (k % 4 == 3) ? int'($urandom_range(20, 64)) : 64;
            ref_win(x, y, w, h);
            do_window(x, y, w, h, (k % 2 == 1));
            take(0, 0);
        end

        // reset during ISSUE
        cur_x = 5; cur_y = 5;
        winX = 5; winY = 5; imgW = 64; imgH = 64;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        check("mid_rst_ready", ready, 1);
        check("mid_rst_rd_en", rd_en, 0);
        check("mid_rst_raddrX", raddrX, 0);
        check("mid_rst_raddrY", raddrY, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_sqsum", sqsum, 0);
        check("mid_rst_variance", variance, 0);
        #3;
        resetn = 1'b1;
        @(posedge clk); #1;
        ref_win(30, 17, 64, 64);
        do_window(30, 17, 64, 64, 0);
        take(2, 0);

        check("ready_done_exclusive", both_seen, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/window_variance_calc.md
# window_variance_calc

Downstream consumer of the integral-image and squared-integral-image caches produced by the integral image generation stage. For one requested detection window it reads the four corner entries from both caches, forms the window pixel sum and squared sum by inclusion–exclusion, and computes the unnormalised variance `WIN*WIN*sqsum - sum*sum`. The classifier stage uses this result for Haar-feature threshold normalisation.

## Interface
Parameters:
- `X_W`, default 10: x coordinate / counter width.
- `Y_W`, default 9: y coordinate / counter width.
- `INT_DATA_W`, default 27: integral cache word width.
- `SQ_DATA_W`, default 35: squared cache word width.
- `WIN`, default 20: window side in pixels.
- `VAR_W`, default 48: variance output width.

Ports:
- `clk`, in, 1: clock. Single clock domain.
- `resetn`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: request a window. Sampled only when `ready`=1.
- `winX`, in, `X_W`: window top-left x, in image pixel coordinates.
- `winY`, in, `Y_W`: window top-left y, in image pixel coordinates.
- `imgW`, in, `X_W`: current scaled image width. Sampled with `start`.
- `imgH`, in, `Y_W`: current scaled image height. Sampled with `start`.
- `ready`, out, 1: idle, accepting `start`.
- `rd_en`, out, 1: read strobe to both caches.
- `raddrX`, out, `X_W`: cache read x (integral coordinates; row 0 and column 0 hold zero).
- `raddrY`, out, `Y_W`: cache read y.
- `int_q`, in, `INT_DATA_W`: integral cache read data. Valid the cycle after the address.
- `sq_q`, in, `SQ_DATA_W`: squared cache read data. Valid the cycle after the address.
- `done`, out, 1: result valid. Held until `taken`.
- `taken`, in, 1: consumer acknowledge. Honoured only while `done`=1.
- `err`, out, 1: window out of bounds. Valid with `done`.
- `sum`, out, `INT_DATA_W`: window pixel sum.
- `sqsum`, out, `SQ_DATA_W`: window squared sum.
- `variance`, out, `VAR_W`: `WIN*WIN*sqsum - sum*sum`.

## Operation
States are IDLE, ISSUE, DRAIN, MULT, SUB and DONE.

**IDLE**
- `ready`=1.
- On `start`, latch `winX`, `winY`, `imgW` and `imgH`.
- If `winX+WIN > imgW` or `winY+WIN > imgH`, go to DONE with `err`=1 and `sum`/`sqsum`/`variance`=0.
- Otherwise clear the accumulators, set `idx`=0 and go to ISSUE.
- The comparison is done in `X_W+1` / `Y_W+1` bits, so there is no wrap.

**ISSUE** (4 cycles)
- `rd_en`=1.
- Corner address by `idx`: 0=A(x,y), 1=B(x+WIN,y), 2=C(x,y+WIN), 3=D(x+WIN,y+WIN).
- `idx` increments each cycle. After `idx`=3, go to DRAIN.

**Accumulate**
- Each returned word is added into `sum`/`sqsum` with sign +A, −B, −C, +D.
- Arithmetic is modulo 2^`INT_DATA_W` / 2^`SQ_DATA_W`. The final window sums are exact because the true window totals fit the word width.

**DRAIN** (1 cycle)
- `rd_en`=0.
- Captures D.
- Goes to MULT.

**MULT**
- Registers `p1 = WIN*WIN*sqsum` and `p2 = sum*sum`, both `VAR_W` wide and zero-extended.

**SUB**
- `variance = p1 - p2`. If `p2 > p1`, `variance` = 0 (saturate; this cannot occur for valid data).
- Goes to DONE.

**DONE**
- `done`=1. `err`, `sum`, `sqsum` and `variance` are held stable.
- On `taken`, go to IDLE.

**Ignored inputs**
- `start` outside IDLE.
- `taken` outside DONE.

**Reset**
- Asynchronous `resetn`=0 forces IDLE from any state, including mid-ISSUE.
- Reset values: `ready`=1, `rd_en`=0, `raddrX`=0, `raddrY`=0, `done`=0, `err`=0, `sum`=0, `sqsum`=0, `variance`=0, `idx`=0.
- In-flight read data is discarded.

## Timing
- `start` is sampled at the end of cycle T.
- Cycles T+1..T+4: ISSUE, with addresses A, B, C, D.
- Read data returns in T+2..T+5, and the accumulator updates at the end of each of those cycles.
- T+5: DRAIN. T+6: MULT. T+7: SUB.
- T+8: `done`=1. Latency from `start` to `done` is 8 cycles.
- Error path: `done`=1 at T+1.
- `taken` sampled at the end of cycle U gives `ready`=1 at U+1. The earliest next `start` is therefore sampled at U+1.
- Throughput is one window per 9 cycles minimum.
- `ready` and `done` are never both 1.

## Test plan
- **Constant image:** all pixels = 10, `WIN`=20, `imgW`=`imgH`=64, window (7,3) → `done` at T+8, `sum`=4000, `sqsum`=40000, `variance`=0, `err`=0. Addresses are (7,3), (27,3), (7,23), (27,23) in T+1..T+4.
- **Checkerboard:** pixels 0/2 checkerboard, window (0,0) → `sum`=400, `sqsum`=800, `variance`=160000.
- **Bounds:**
  - `imgW`=24, `winX`=5 → `done` at T+1, `err`=1, all results 0, `rd_en` never asserted.
  - `winX`=4 → accepted, highest read x = 24.
- **Modular wrap:** force corner words A=134217700, B=50, C=60, D=4100 (`INT_DATA_W`=27) → `sum`=3962.
- **Handshake:**
  - `taken` delayed 5 cycles → outputs stable throughout.
  - `start` pulses during ISSUE/DONE → ignored.
  - `taken` in IDLE → ignored.
  - Back-to-back windows at 9-cycle spacing → both results correct.
- **Reset mid-operation:**
  - Drop `resetn` at T+3 → all outputs immediately at reset values.
  - Release, then a fresh `start` → correct result with full 8-cycle latency.
